// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Two-stage execute unit for the EX slot. Stage 1 registers the operation
// (op code plus both operands); stage 2 registers the ALU result and the
// illegal-op flag. A valid/ready handshake on both sides allows one operation
// per cycle under no backpressure, and a synchronous flush drops everything
// in flight on a branch redirect.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // Op codes as emitted by the ALU control decoder.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // Stage 1 state: the accepted operation waiting to be evaluated.
  logic             s1_valid_reg;
  logic [2:0]       s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  // Stage 2 state: the evaluated result presented downstream.
  logic             s2_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             illegal_reg;

  // Handshake terms.
  logic s2_take;
  logic s1_adv;
  logic accept;

  // ALU datapath terms.
  logic [WIDTH-1:0] and_vec;
  logic [WIDTH-1:0] or_vec;
  logic [WIDTH-1:0] xor_vec;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] diff_vec;
  logic             slt_bit;
  logic             sltu_bit;
  logic [WIDTH-1:0] result_next;
  logic             illegal_next;

  // S2 can load when it is empty or being popped this cycle; S1 can then
  // hand its operation over, and the input side can refill S1 in the same
  // edge. in_ready is purely combinational from out_ready and stage state.
  assign s2_take  = !s2_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_take;
  assign in_ready = !s1_valid_reg || s2_take;
  // A flush in the same cycle discards the acceptance.
  assign accept   = in_valid && in_ready && !flush;

  // Bitwise logic ops, one slice per bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_vec[gi] = s1_a_reg[gi] & s1_b_reg[gi];
      assign or_vec[gi]  = s1_a_reg[gi] | s1_b_reg[gi];
      assign xor_vec[gi] = s1_a_reg[gi] ^ s1_b_reg[gi];
    end
  endgenerate

  // Arithmetic and comparisons wrap modulo 2^WIDTH; no overflow flag.
  assign sum_vec  = s1_a_reg + s1_b_reg;
  assign diff_vec = s1_a_reg - s1_b_reg;
  assign slt_bit  = $signed(s1_a_reg) < $signed(s1_b_reg);
  assign sltu_bit = s1_a_reg < s1_b_reg;

  // Select the result for the op held in S1; op 111 yields zero plus the
  // illegal flag but still travels through the pipe like any other op.
  always_comb begin
    result_next  = '0;
    illegal_next = 1'b0;
    case (s1_op_reg)
      OP_ADD:  result_next = sum_vec;
      OP_SUB:  result_next = diff_vec;
      OP_AND:  result_next = and_vec;
      OP_OR:   result_next = or_vec;
      OP_XOR:  result_next = xor_vec;
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_ILL:  illegal_next = 1'b1;
      default: illegal_next = 1'b1;
    endcase
  end

  // Stage 1 valid: flush wins, then a new acceptance, then drain on advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 1 data: captured only on a real acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_op_reg <= OP_ADD;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
    end else if (accept) begin
      s1_op_reg <= alu_control;
      s1_a_reg  <= src_a;
      s1_b_reg  <= src_b;
    end
  end

  // Stage 2 valid: flush wins, then load from S1, otherwise drop on a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
    end else if (flush) begin
      s2_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_reg <= 1'b1;
    end else if (out_ready) begin
      s2_valid_reg <= 1'b0;
    end
  end

  // Stage 2 data: changes only when S1 advances, so a stalled result holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else if (s1_adv && !flush) begin
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
    end
  end

  // zero is decoded from the registered result so it always matches it.
  assign out_valid = s2_valid_reg;
  assign result    = result_reg;
  assign illegal   = illegal_reg;
  assign zero      = (result_reg == '0);

endmodule
